// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction-fetch front end with valid/ready issue, jumps and halt
module fetch_sequencer #(
    parameter int                ADDR_W      = 4,
    parameter int                INSN_W      = 8,
    parameter logic [INSN_W-1:0] HALT_OPCODE = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    output logic [ADDR_W-1:0] o_imem_addr,
    input  logic [INSN_W-1:0] i_imem_data,
    output logic [INSN_W-1:0] o_insn,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_insn_valid,
    input  logic              i_insn_ready,
    input  logic              i_jump_en,
    input  logic [ADDR_W-1:0] i_jump_addr,
    output logic              o_halted
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [INSN_W-1:0] r_insn;
    logic [ADDR_W-1:0] r_insn_pc;
    logic              r_valid;
    logic              r_halted;

    logic [ADDR_W-1:0] w_pc_next;
    logic [INSN_W-1:0] w_insn_next;
    logic [ADDR_W-1:0] w_insn_pc_next;
    logic              w_valid_next;
    logic              w_halted_next;
    logic              w_handshake;
    logic              w_is_halt;

    assign w_handshake = r_valid & i_insn_ready;
    assign w_is_halt   = (i_imem_data == HALT_OPCODE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (i_run) w_state_next = FETCH;
            FETCH:   w_state_next = w_is_halt ? HALT : ISSUE;
            ISSUE:   if (w_handshake) w_state_next = FETCH;
            HALT:    if (i_run) w_state_next = FETCH;
            default: w_state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs and PC; everything holds unless the state acts on it.
    always_comb begin
        w_pc_next      = r_pc;
        w_insn_next    = r_insn;
        w_insn_pc_next = r_insn_pc;
        w_valid_next   = r_valid;
        w_halted_next  = r_halted;
        case (r_state)
            FETCH: begin
                w_insn_next    = i_imem_data;
                w_insn_pc_next = r_pc;
                if (w_is_halt) begin
                    w_halted_next = 1'b1;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            ISSUE: begin
                if (w_handshake) begin
                    w_valid_next = 1'b0;
                    w_pc_next    = i_jump_en ? i_jump_addr : r_pc + ADDR_W'(1);
                end
            end
            HALT: begin
                if (i_run) begin
                    w_halted_next = 1'b0;
                    w_pc_next     = i_jump_en ? i_jump_addr : r_pc;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= '0;
            r_insn    <= '0;
            r_insn_pc <= '0;
            r_valid   <= 1'b0;
            r_halted  <= 1'b0;
        end else begin
            r_pc      <= w_pc_next;
            r_insn    <= w_insn_next;
            r_insn_pc <= w_insn_pc_next;
            r_valid   <= w_valid_next;
            r_halted  <= w_halted_next;
        end
    end

    assign o_imem_addr  = r_pc;
    assign o_insn       = r_insn;
    assign o_pc         = r_insn_pc;
    assign o_insn_valid = r_valid;
    assign o_halted     = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard bench for fetch_sequencer
module tb_fetch_sequencer;

    logic       clk;
    logic       rst;
    logic       i_run;
    logic [3:0] o_imem_addr;
    logic [7:0] i_imem_data;
    logic [7:0] o_insn;
    logic [3:0] o_pc;
    logic       o_insn_valid;
    logic       i_insn_ready;
    logic       i_jump_en;
    logic [3:0] i_jump_addr;
    logic       o_halted;

    typedef struct packed {
        logic [3:0] pc;
        logic [7:0] insn;
    } issue_t;

    logic [7:0] mem [16];
    issue_t     sb[$];
    issue_t     exp_i;
    int         checks;
    int         errors;

    fetch_sequencer #(.ADDR_W(4), .INSN_W(8), .HALT_OPCODE(8'hFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_run        (i_run),
        .o_imem_addr  (o_imem_addr),
        .i_imem_data  (i_imem_data),
        .o_insn       (o_insn),
        .o_pc         (o_pc),
        .o_insn_valid (o_insn_valid),
        .i_insn_ready (i_insn_ready),
        .i_jump_en    (i_jump_en),
        .i_jump_addr  (i_jump_addr),
        .o_halted     (o_halted)
    );

    assign i_imem_data = mem[o_imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (o_insn_valid !== 1'b0 || o_halted !== 1'b0 || o_insn !== 8'h00 || o_pc !== 4'h0 || o_imem_addr !== 4'h0) begin
            errors++;
            $display("FAIL reset: valid=%b halted=%b insn=%h pc=%h addr=%h, expected all zero",
                     o_insn_valid, o_halted, o_insn, o_pc, o_imem_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_insn_valid !== 1'b0 || o_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b halted=%b, expected 0 0", o_insn_valid, o_halted);
        end
    endtask

    task automatic test_sequential();
        int last;
        sb.push_back('{4'h0, 8'h11});
        sb.push_back('{4'h1, 8'h22});
        sb.push_back('{4'h2, 8'h33});
        i_insn_ready = 1'b1;
        i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        checks++;
        if (o_insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL start_fetch: valid=%b, expected 0 during FETCH", o_insn_valid);
        end
        last = -1;
        for (int c = 0; c < 20 && o_halted !== 1'b1; c++) begin
            @(negedge clk);
            if (o_insn_valid === 1'b1) begin
                exp_i = sb.pop_front();
                checks++;
                if ({o_pc, o_insn} !== exp_i) begin
                    errors++;
                    $display("FAIL seq_issue: got pc=%h insn=%h, expected pc=%h insn=%h",
                             o_pc, o_insn, exp_i.pc, exp_i.insn);
                end
                checks++;
                if (last < 0 && c != 0) begin
                    errors++;
                    $display("FAIL start_latency: first valid at cycle %0d, expected 0", c);
                end else if (last >= 0 && c - last != 2) begin
                    errors++;
                    $display("FAIL seq_spacing: gap %0d cycles, expected 2", c - last);
                end
                last = c;
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL seq_count: %0d issues missing, expected 0", sb.size());
            sb.delete();
        end
        checks++;
        if (o_halted !== 1'b1 || o_pc !== 4'h3 || o_insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL seq_halt: halted=%b pc=%h valid=%b, expected 1 3 0", o_halted, o_pc, o_insn_valid);
        end
    endtask

    task automatic test_restart_jump();
        i_insn_ready = 1'b0;
        i_run = 1'b1;
        i_jump_en = 1'b1;
        i_jump_addr = 4'h0;
        @(negedge clk);
        i_run = 1'b0;
        i_jump_en = 1'b0;
        checks++;
        if (o_halted !== 1'b0 || o_insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart_fall: halted=%b valid=%b, expected 0 0", o_halted, o_insn_valid);
        end
        sb.push_back('{4'h0, 8'h11});
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL restart_issue: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
    endtask

    task automatic test_backpressure();
        i_insn_ready = 1'b1;
        @(negedge clk);
        i_insn_ready = 1'b0;
        sb.push_back('{4'h1, 8'h22});
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL bp_first: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
        for (int k = 0; k < 4; k++) begin
            i_jump_en = (k % 2 == 0);
            i_jump_addr = 4'h9;
            @(negedge clk);
            checks++;
            if (o_insn_valid !== 1'b1 || o_pc !== 4'h1 || o_insn !== 8'h22) begin
                errors++;
                $display("FAIL bp_stall%0d: valid=%b pc=%h insn=%h, expected 1 1 22", k, o_insn_valid, o_pc, o_insn);
            end
        end
        i_jump_en = 1'b0;
        i_insn_ready = 1'b1;
        sb.push_back('{4'h2, 8'h33});
        @(negedge clk);
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL bp_next: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
        @(negedge clk);
        @(negedge clk);
        i_insn_ready = 1'b0;
        checks++;
        if (o_halted !== 1'b1 || o_insn_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_halt: halted=%b valid=%b, expected 1 0", o_halted, o_insn_valid);
        end
    endtask

    task automatic test_restart_refetch();
        i_run = 1'b1;
        i_jump_en = 1'b0;
        @(negedge clk);
        i_run = 1'b0;
        checks++;
        if (o_halted !== 1'b0 || o_insn_valid !== 1'b0 || o_imem_addr !== 4'h3) begin
            errors++;
            $display("FAIL refetch_fetch: halted=%b valid=%b addr=%h, expected 0 0 3", o_halted, o_insn_valid, o_imem_addr);
        end
        @(negedge clk);
        checks++;
        if (o_halted !== 1'b1 || o_insn_valid !== 1'b0 || o_pc !== 4'h3) begin
            errors++;
            $display("FAIL refetch_halt: halted=%b valid=%b pc=%h, expected 1 0 3", o_halted, o_insn_valid, o_pc);
        end
    endtask

    task automatic test_jump_handshake();
        i_insn_ready = 1'b0;
        i_run = 1'b1;
        i_jump_en = 1'b1;
        i_jump_addr = 4'h1;
        @(negedge clk);
        i_run = 1'b0;
        i_jump_en = 1'b0;
        sb.push_back('{4'h1, 8'h22});
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL jump_pre: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
        i_insn_ready = 1'b1;
        i_jump_en = 1'b1;
        i_jump_addr = 4'hA;
        sb.push_back('{4'hA, mem[10]});
        @(negedge clk);
        i_insn_ready = 1'b0;
        i_jump_en = 1'b0;
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL jump_target: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
    endtask

    task automatic test_wrap();
        i_insn_ready = 1'b1;
        i_jump_en = 1'b1;
        i_jump_addr = 4'hF;
        sb.push_back('{4'hF, 8'h5A});
        @(negedge clk);
        i_insn_ready = 1'b0;
        i_jump_en = 1'b0;
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL wrap_top: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
        i_insn_ready = 1'b1;
        sb.push_back('{4'h0, 8'h11});
        @(negedge clk);
        i_insn_ready = 1'b0;
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i) begin
            errors++;
            $display("FAIL wrap_zero: valid=%b pc=%h insn=%h, expected 1 pc=%h insn=%h",
                     o_insn_valid, o_pc, o_insn, exp_i.pc, exp_i.insn);
        end
    endtask

    task automatic test_reset_mid_issue();
        i_insn_ready = 1'b1;
        sb.push_back('{4'h1, 8'h22});
        @(negedge clk);
        i_insn_ready = 1'b0;
        @(negedge clk);
        exp_i = sb.pop_front();
        checks++;
        if (o_insn_valid !== 1'b1 || {o_pc, o_insn} !== exp_i || o_imem_addr !== 4'h1) begin
            errors++;
            $display("FAIL mid_pre: valid=%b pc=%h insn=%h addr=%h, expected 1 pc=%h insn=%h addr=1",
                     o_insn_valid, o_pc, o_insn, o_imem_addr, exp_i.pc, exp_i.insn);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (o_insn_valid !== 1'b0 || o_halted !== 1'b0 || o_insn !== 8'h00 || o_pc !== 4'h0 || o_imem_addr !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: valid=%b halted=%b insn=%h pc=%h addr=%h, expected all zero",
                     o_insn_valid, o_halted, o_insn, o_pc, o_imem_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        i_run = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (o_insn_valid !== 1'b0 || o_halted !== 1'b0 || o_imem_addr !== 4'h0) begin
                errors++;
                $display("FAIL idle_hold%0d: valid=%b halted=%b addr=%h, expected 0 0 0", k, o_insn_valid, o_halted, o_imem_addr);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        i_run = 1'b0;
        i_insn_ready = 1'b0;
        i_jump_en = 1'b0;
        i_jump_addr = 4'h0;
        for (int i = 0; i < 16; i++) mem[i] = 8'h80 | 8'(i);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;
        mem[3] = 8'hFF;
        mem[15] = 8'h5A;

        test_reset();
        test_sequential();
        test_restart_jump();
        test_backpressure();
        test_restart_refetch();
        test_jump_handshake();
        test_wrap();
        test_reset_mid_issue();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
